alu_bist: RTL and testbench

Built-in self-test sequencer for the 4-bit ALU (add, subtract, AND, OR). On a start pulse it drives all 1024 `{sel, a, b}` combinations into the ALU, one per clock. It compares `out`/`carry_out` against an internal reference model each cycle and reports pass/fail, a saturating error count and the first failing vector. It sits beside the ALU on the tapeout die as the hardware counterpart of the simulation stimulus bench.

---
 rtl/alu_bist.sv | 110 +++++++++++
 tb/tb_alu_bist.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_bist.sv
// Built-in self-test sequencer for the 4-bit add/sub/and/or ALU: sweeps all 1024
// {sel,a,b} vectors and checks each response. Define ALU_BIST_EARLY_STOP_EN to halt on the first mismatch.
module alu_bist #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_sel,
  input  logic [3:0]       alu_out,
  input  logic             alu_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [9:0]       first_fail
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DONE
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [9:0]       VEC_LAST = 10'h3FF;

  state_t     state;
  logic [9:0] vec;
  logic [4:0] exp_res;
  logic       mismatch;

  // The drive outputs are the vector register itself, so they are registered and
  // hold their last value once the sweep stops.
  assign alu_sel = vec[9:8];
  assign alu_a   = vec[7:4];
  assign alu_b   = vec[3:0];

  // Reference model: bit 4 is the carry (add) or the borrow (sub).
  always_comb begin
    // NOTE: default first so no path through the case leaves exp_res unassigned (no latch).
    exp_res = '0;
    unique case (alu_sel)
      2'b00: exp_res = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: exp_res = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10: exp_res = {1'b0, alu_a & alu_b};
      2'b11: exp_res = {1'b0, alu_a | alu_b};
    endcase
    mismatch = ({alu_out, alu_carry} != {exp_res[3:0], exp_res[4]});
  end

  // NOTE: all state is written with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= CHECK;
            vec        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
          end
        end

        CHECK: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
            if (!fail_valid) begin
              first_fail <= vec;
              fail_valid <= 1'b1;
            end
          end
`ifdef ALU_BIST_EARLY_STOP_EN
          if (mismatch || vec == VEC_LAST) begin
`else
          if (vec == VEC_LAST) begin
`endif
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // fail_valid still holds its pre-edge value, so fold in this cycle's result.
            pass  <= !(fail_valid || mismatch);
          end else begin
            vec <= vec + 10'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: a behavioural ALU with selectable stuck-at faults
// answers the sequencer, and each run's results are checked against hand-derived values.
module tb_alu_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [1:0] alu_sel;
  logic       alu_carry;
  logic       busy, done, pass, fail_valid;
  logic [7:0] err_count;
  logic [9:0] first_fail;

  // 0 = golden ALU, 1 = carry_out stuck at 0, 2 = out[0] stuck at 0
  logic [1:0] fault_mode;
  logic [4:0] alu_res;

  int tests = 0;
  int fails = 0;
  int n;

  alu_bist #(.ERR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .first_fail (first_fail)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_res = '0;
    case (alu_sel)
      2'b00:   alu_res = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   alu_res = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   alu_res = {1'b0, alu_a & alu_b};
      default: alu_res = {1'b0, alu_a | alu_b};
    endcase
    alu_out   = alu_res[3:0];
    alu_carry = alu_res[4];
    if (fault_mode == 2'd1) alu_carry  = 1'b0;
    if (fault_mode == 2'd2) alu_out[0] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    run_edge();
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done; optionally re-pulses start mid-run.
  task automatic wait_done(input int pulse_at, output int edges);
    edges = 0;
    while (!done && edges < 3000) begin
      if (edges == pulse_at) start = 1'b1;
      run_edge();
      start = 1'b0;
      edges++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_status"}, {28'd0, busy, done, pass, fail_valid}, 32'd0);
    check({tag, "_err"}, {24'd0, err_count}, 32'd0);
    check({tag, "_ff"}, {22'd0, first_fail}, 32'd0);
    check({tag, "_drive"}, {22'd0, alu_sel, alu_a, alu_b}, 32'd0);
  endtask

  task automatic check_result(input string tag, input int edges, input int exp_edges,
                              input logic exp_pass, input logic [7:0] exp_err,
                              input logic exp_fv, input logic [9:0] exp_ff,
                              input logic [9:0] exp_drive);
    check({tag, "_edges"}, edges, exp_edges);
    check({tag, "_busy_done"}, {30'd0, busy, done}, 32'd1);
    check({tag, "_pass"}, {31'd0, pass}, {31'd0, exp_pass});
    check({tag, "_err"}, {24'd0, err_count}, {24'd0, exp_err});
    check({tag, "_fv"}, {31'd0, fail_valid}, {31'd0, exp_fv});
    check({tag, "_ff"}, {22'd0, first_fail}, {22'd0, exp_ff});
    check({tag, "_drive"}, {22'd0, alu_sel, alu_a, alu_b}, {22'd0, exp_drive});
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    fault_mode = 2'd0;
    run_edge();
    run_edge();
    check_zero("reset");
    rst = 1'b0;
    run_edge();
    check_zero("idle");

    // Golden ALU, with a start re-pulse around cycle 300 that must be ignored.
    pulse_start();
    check("start_busy", {30'd0, busy, done}, 32'd2);
    check("start_drive", {22'd0, alu_sel, alu_a, alu_b}, 32'd0);
    run_edge();
    check("second_vec", {22'd0, alu_sel, alu_a, alu_b}, 32'd1);
    wait_done(299, n);
    check_result("golden", n + 1, 1024, 1'b1, 8'd0, 1'b0, 10'd0, 10'h3FF);

    // Results stay stable while done holds.
    run_edge();
    run_edge();
    check_result("golden_hold", 1024, 1024, 1'b1, 8'd0, 1'b0, 10'd0, 10'h3FF);

    // Restart from DONE: done drops on the start edge and the run repeats.
    pulse_start();
    check("restart_busy", {30'd0, busy, done}, 32'd2);
    check("restart_drive", {22'd0, alu_sel, alu_a, alu_b}, 32'd0);
    wait_done(-1, n);
    check_result("golden2", n, 1024, 1'b1, 8'd0, 1'b0, 10'd0, 10'h3FF);

    // carry_out stuck at 0: first failure is 1+15 (vector 0x01F).
    fault_mode = 2'd1;
    pulse_start();
    wait_done(-1, n);
`ifdef ALU_BIST_EARLY_STOP_EN
    check_result("carry0", n, 32, 1'b0, 8'd1, 1'b1, 10'h01F, 10'h01F);
`else
    check_result("carry0", n, 1024, 1'b0, 8'd240, 1'b1, 10'h01F, 10'h3FF);
`endif

    // out[0] stuck at 0: 512 mismatches saturate the counter; first is 0+1.
    fault_mode = 2'd2;
    pulse_start();
    wait_done(-1, n);
`ifdef ALU_BIST_EARLY_STOP_EN
    check_result("out0", n, 2, 1'b0, 8'd1, 1'b1, 10'h001, 10'h001);
`else
    check_result("out0", n, 1024, 1'b0, 8'd255, 1'b1, 10'h001, 10'h3FF);
`endif

    // Reset mid-run, with errors already accumulated.
    pulse_start();
    for (int i = 0; i < 499; i++) run_edge();
    check("midrun_busy", {30'd0, busy, done}, 32'd2);
    rst = 1'b1;
    run_edge();
    check_zero("midrun_rst");
    rst = 1'b0;
    fault_mode = 2'd0;
    run_edge();
    check_zero("post_rst_idle");
    pulse_start();
    wait_done(-1, n);
    check_result("after_rst", n, 1024, 1'b1, 8'd0, 1'b0, 10'd0, 10'h3FF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
